bip_sequencer: RTL and testbench

Instruction sequencer for the BIP processor. Owns the program counter, fetches 16-bit instructions from the synchronous-read program memory, and presents each one to the `control` block for exactly one execute cycle. Handles the halt opcode and reports run/halt status and a retired-instruction count to the top level.

---
 rtl/bip_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_bip_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bip_sequencer.sv
// bip_sequencer -- instruction sequencer for the BIP processor.
//
// Owns the program counter, fetches 16-bit instructions from a synchronous-read
// program memory (1-cycle latency) and presents each instruction to the control
// block for exactly one EXEC cycle. Opcode 5'b00000 (HLT) stops the sequencer.
//
// Optional feature macro: BIP_SINGLE_STEP_EN (adds i_step_mode / i_step and a
// PAUSE state entered after every non-HLT instruction while step mode is on).
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_start        start / restart request (honoured in IDLE and HALTED only)
//   i_step_mode    (BIP_SINGLE_STEP_EN) pause after every instruction
//   i_step         (BIP_SINGLE_STEP_EN) leave PAUSE for the next fetch
//   i_instr_data   program memory read data, valid one cycle after o_instr_rd
//   o_pc_addr      program memory address (current PC)
//   o_instr_rd     program memory read enable (FETCH)
//   o_instruction  instruction for control; 0 (HLT, harmless) outside EXEC
//   o_instr_valid  high during EXEC only
//   o_running      high in FETCH, LOAD, EXEC, PAUSE
//   o_halted       high in HALTED
//   o_retired      instructions executed since the last start (saturating)
module bip_sequencer #(
   parameter int PC_WIDTH     = 11,
   parameter int INSTR_WIDTH  = 16,
   parameter int OPCODE_WIDTH = 5
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_start,
`ifdef BIP_SINGLE_STEP_EN
   input  logic                   i_step_mode,
   input  logic                   i_step,
`endif
   input  logic [INSTR_WIDTH-1:0] i_instr_data,
   output logic [PC_WIDTH-1:0]    o_pc_addr,
   output logic                   o_instr_rd,
   output logic [INSTR_WIDTH-1:0] o_instruction,
   output logic                   o_instr_valid,
   output logic                   o_running,
   output logic                   o_halted,
   output logic [15:0]            o_retired
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALTED = 3'd4,
      ST_PAUSE  = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] ir_q, ir_d;
   logic [15:0]            retired_q, retired_d;
   logic                   is_hlt;

   // HLT is an all-zero opcode field in the instruction MSBs.
   assign is_hlt = (ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH] == {OPCODE_WIDTH{1'b0}});

   // State and datapath registers; reset discards any in-flight instruction.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= ST_IDLE;
         pc_q      <= {PC_WIDTH{1'b0}};
         ir_q      <= {INSTR_WIDTH{1'b0}};
         retired_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         retired_q <= retired_d;
      end
   end

   // Next-state and next-datapath logic.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      retired_d = retired_q;
      case (state_q)
         ST_IDLE, ST_HALTED: begin
            if (i_start) begin
               pc_d      = {PC_WIDTH{1'b0}};
               retired_d = 16'h0000;
               state_d   = ST_FETCH;
            end else begin
               state_d   = state_q;
            end
         end
         ST_FETCH: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            // Memory data for the FETCH address is valid during this cycle.
            ir_d    = i_instr_data;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (retired_q != 16'hFFFF) begin
               retired_d = retired_q + 16'h0001;
            end else begin
               retired_d = retired_q;
            end
            if (is_hlt) begin
               // PC stays on the HLT address, so no wrap at the last address.
               state_d = ST_HALTED;
            end else begin
               pc_d = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
`ifdef BIP_SINGLE_STEP_EN
               if (i_step_mode) begin
                  state_d = ST_PAUSE;
               end else begin
                  state_d = ST_FETCH;
               end
`else
               state_d = ST_FETCH;
`endif
            end
         end
`ifdef BIP_SINGLE_STEP_EN
         ST_PAUSE: begin
            // Leaving step mode also releases the pause.
            if (i_step || !i_step_mode) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_PAUSE;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs decoded from the state register only (no input-to-output path).
   always_comb begin
      o_instr_rd    = 1'b0;
      o_instruction = {INSTR_WIDTH{1'b0}};
      o_instr_valid = 1'b0;
      o_running     = 1'b0;
      o_halted      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            o_running = 1'b0;
         end
         ST_FETCH: begin
            o_instr_rd = 1'b1;
            o_running  = 1'b1;
         end
         ST_LOAD: begin
            o_running = 1'b1;
         end
         ST_EXEC: begin
            o_running     = 1'b1;
            o_instr_valid = 1'b1;
            o_instruction = ir_q;
         end
         ST_HALTED: begin
            o_halted = 1'b1;
         end
`ifdef BIP_SINGLE_STEP_EN
         ST_PAUSE: begin
            o_running = 1'b1;
         end
`endif
         default: begin
            o_running = 1'b0;
         end
      endcase
   end

   assign o_pc_addr = pc_q;
   assign o_retired = retired_q;

endmodule

// File: tb/tb_bip_sequencer.sv
module tb_bip_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [15:0] rdata = 16'h0000;
   logic [10:0] o_pc_addr;
   logic        o_instr_rd;
   logic [15:0] o_instruction;
   logic        o_instr_valid;
   logic        o_running;
   logic        o_halted;
   logic [15:0] o_retired;
`ifdef BIP_SINGLE_STEP_EN
   logic        i_step_mode = 1'b0;
   logic        i_step = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:2047];
   logic [15:0] exp_ins[$];
   int          exp_pcs[$];

   bip_sequencer dut (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_start       (i_start),
`ifdef BIP_SINGLE_STEP_EN
      .i_step_mode   (i_step_mode),
      .i_step        (i_step),
`endif
      .i_instr_data  (rdata),
      .o_pc_addr     (o_pc_addr),
      .o_instr_rd    (o_instr_rd),
      .o_instruction (o_instruction),
      .o_instr_valid (o_instr_valid),
      .o_running     (o_running),
      .o_halted      (o_halted),
      .o_retired     (o_retired)
   );

   always #5 clk = ~clk;

   // Synchronous-read program memory, one cycle latency.
   always @(posedge clk) begin
      if (o_instr_rd) rdata <= mem[o_pc_addr];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {17'd0, o_pc_addr, o_instr_rd, o_instruction, o_instr_valid,
              o_running, o_halted, o_retired};
   endfunction

   function automatic logic [15:0] rand_nonhlt();
      logic [15:0] v;
      v = 16'($urandom);
      v[15:11] = 5'($urandom_range(1, 31));
      return v;
   endfunction

   // Reference: walk the program as the processor would, recording each
   // executed instruction and its address, until a HLT opcode.
   task automatic build_model(input bit patch0, output int final_pc, output int n);
      logic [15:0] m [0:2047];
      logic [15:0] ins;
      int pc;
      for (int i = 0; i < 2048; i++) m[i] = mem[i];
      exp_ins.delete();
      exp_pcs.delete();
      pc = 0;
      n = 0;
      while (n < 70000) begin
         ins = m[pc];
         exp_ins.push_back(ins);
         exp_pcs.push_back(pc);
         n++;
         if (patch0 && n == 1) m[0] = 16'h0000;
         if (ins[15:11] == 5'd0) break;
         pc = (pc + 1) % 2048;
      end
      final_pc = pc;
   endtask

   task automatic run_prog(input string tag, input bit patch0, input int max_cycles);
      int fpc, n, idx, last, cyc, exp_ret;
      build_model(patch0, fpc, n);
      @(negedge clk) i_start = 1'b1;
      @(negedge clk) i_start = 1'b0;
      // First cycle after start: FETCH at address 0 with a cleared count.
      check({tag, "_fetch"}, {o_retired, o_pc_addr, o_instr_rd, o_running},
            {16'h0000, 11'd0, 1'b1, 1'b1});
      idx = 0; last = 0; cyc = 0;
      while (o_halted !== 1'b1 && cyc < max_cycles) begin
         check({tag, "_running"}, o_running, 1'b1);
         if (o_instr_valid === 1'b1) begin
            if (idx < n) begin
               check({tag, "_instr"}, o_instruction, exp_ins[idx]);
               check({tag, "_pc"}, o_pc_addr, exp_pcs[idx]);
            end else begin
               check({tag, "_extra_exec"}, idx, n - 1);
            end
            if (idx == 0) check({tag, "_first_exec_cycle"}, cyc, 2);
            else check({tag, "_exec_spacing"}, cyc - last, 3);
            if (n < 100) check({tag, "_retired_in_exec"}, o_retired, idx);
            if (patch0 && idx == 0) mem[0] = 16'h0000;
            last = cyc;
            idx++;
         end
         @(negedge clk);
         cyc++;
      end
      exp_ret = (n > 65535) ? 65535 : n;
      check({tag, "_halted"}, o_halted, 1'b1);
      check({tag, "_exec_count"}, idx, n);
      check({tag, "_halt_pc"}, o_pc_addr, fpc);
      check({tag, "_retired"}, o_retired, exp_ret);
      check({tag, "_halt_quiet"}, {o_running, o_instr_valid, o_instr_rd, o_instruction},
            {3'b000, 16'h0000});
   endtask

   initial begin
      int k;
      for (int i = 0; i < 2048; i++) mem[i] = rand_nonhlt();

      // Reset and idle.
      repeat (3) @(negedge clk);
      check("in_reset_outputs", all_outs(), 64'd0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_outputs", all_outs(), 64'd0);

      // Directed three-instruction program, then restart from HALTED.
      mem[0] = 16'h2801; mem[1] = 16'h2801; mem[2] = 16'h0000;
      run_prog("dir", 1'b0, 50);
      repeat (3) @(negedge clk);
      check("halted_holds", {o_halted, o_pc_addr, o_retired}, {1'b1, 11'd2, 16'd3});
      run_prog("restart", 1'b0, 50);

      // Random programs with a HLT at a random address.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 64; i++) mem[i] = rand_nonhlt();
         k = $urandom_range(0, 40);
         mem[k] = {5'd0, 11'($urandom)};
         run_prog("rand", 1'b0, 200);
      end

      // HLT at the last address: PC must not wrap.
      for (int i = 0; i < 2047; i++) mem[i] = rand_nonhlt();
      mem[2047] = {5'd0, 11'h5a5};
      run_prog("hlt_last", 1'b0, 6300);

      // Wrap-around: no HLT in 0..2047 first pass, HLT at 0 after wrap.
      mem[2047] = rand_nonhlt();
      run_prog("wrap", 1'b1, 6300);

      // Asynchronous reset during LOAD.
      mem[0] = rand_nonhlt(); mem[1] = 16'h0000;
      @(negedge clk) i_start = 1'b1;
      @(negedge clk) i_start = 1'b0;
      check("pre_reset_fetch", o_instr_rd, 1'b1);
      @(negedge clk);
      check("pre_reset_load", {o_running, o_instr_rd}, 2'b10);
      #2 rst_n = 1'b0;
      #1 check("async_reset_outputs", all_outs(), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("post_reset_idle", all_outs(), 64'd0);
      run_prog("after_reset", 1'b0, 50);

`ifdef BIP_SINGLE_STEP_EN
      begin
         int cyc, nvalid;
         for (int i = 0; i < 4; i++) mem[i] = rand_nonhlt();
         mem[4] = 16'h0000;
         i_step_mode = 1'b1;
         @(negedge clk) i_start = 1'b1;
         @(negedge clk) i_start = 1'b0;
         cyc = 0;
         while (o_instr_valid !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
         check("step_first_exec", o_instr_valid, 1'b1);
         repeat (6) begin
            @(negedge clk);
            check("step_paused", {o_instr_valid, o_running, o_instr_rd}, 3'b010);
         end
         i_step = 1'b1;
         @(negedge clk) i_step = 1'b0;
         nvalid = 0;
         repeat (8) begin
            if (o_instr_valid === 1'b1) nvalid++;
            @(negedge clk);
         end
         check("step_one_exec", nvalid, 1);
         i_step_mode = 1'b0;
         cyc = 0;
         while (o_halted !== 1'b1 && cyc < 30) begin @(negedge clk); cyc++; end
         check("step_drain", {o_halted, o_retired}, {1'b1, 16'd5});
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
